case_convert_stream: RTL and testbench
======================================

// Module: case_convert_stream
// PURPOSE
//  Streaming ASCII case converter with valid/ready handshake. Processes LANES bytes per beat.
//  Modes: pass, upper, lower, toggle. Only letters a-z / A-Z are modified; every other byte passes unchanged.
//  Registered output with a 2-entry skid buffer, so in_ready is a flop.
//  Sits between the UART/byte-stream front end and downstream text consumers.
//  Keeps a saturating count of bytes actually changed.
// PARAMETERS
//  LANES    4   bytes per beat (>=1); data width 8*LANES
//  CNT_W    16  width of changed-byte counter (>=1)
// PORTS
//  clk        in   1          single clock, all logic on rising edge
//  rst        in   1          synchronous reset, active-high
//  mode       in   2          00 pass, 01 upper, 10 lower, 11 toggle; sampled per accepted beat
//  in_valid   in   1          input beat valid
//  in_ready   out  1          block can accept a beat (registered)
//  in_data    in   8*LANES    lane i = in_data[8i+7:8i]
//  in_keep    in   LANES      1 = lane carries a byte; 0 = lane forwarded untouched, not counted
//  out_valid  out  1          output beat valid
//  out_ready  in   1          downstream accepts
//  out_data   out  8*LANES    converted data
//  out_keep   out  LANES      in_keep, delayed with its data
//  cnt_clr    in   1          clear changed-byte counter
//  chg_cnt    out  CNT_W      saturating count of bytes whose value changed
// BEHAVIOUR
//  - Reset: in_ready=0 in the reset cycle, 1 on the first cycle after rst deasserts.
//    out_valid=0; out_data=0; out_keep=0; chg_cnt=0; skid buffer empty.
//  - Accept occurs when in_valid&in_ready. Emit occurs when out_valid&out_ready.
//  - Per-lane conversion is combinational on accept and stored already converted:
//      letter  = (b in 8'h41..8'h5A) | (b in 8'h61..8'h7A)
//      upper:  letter & b[5] -> b[5]=0
//      lower:  letter & ~b[5] -> b[5]=1
//      toggle: letter -> b[5]=~b[5]
//      pass:   unchanged
//    Only bit 5 may ever differ between input and output.
//  - Latency: an accepted beat appears on out_* the next cycle when the output stage is empty or draining.
//  - Throughput: 1 beat/clk while out_ready=1.
//  - Ordering: strict FIFO; beats are never dropped or duplicated.
//  - Output stage (main reg) plus skid reg, with occupancy states:
//      EMPTY (0 beats), ONE (main valid), TWO (main+skid valid).
//      EMPTY --accept--> ONE
//      ONE   --accept&~emit--> TWO
//      ONE   --emit&~accept--> EMPTY
//      ONE   --accept&emit--> ONE
//      TWO   --emit--> ONE (skid moves to main)
//      TWO never accepts.
//    in_ready is registered = (next state != TWO).
//  - out_data/out_keep are held stable while out_valid & ~out_ready (AXI-style; no change until emit).
//  - mode changes apply only to beats accepted after the change; stored beats are not reconverted.
//  - chg_cnt increments by the number of kept lanes whose converted value != input value, on accept.
//    The increment ranges 0..LANES per cycle. The counter saturates at 2^CNT_W-1 and never wraps.
//  - cnt_clr: chg_cnt=0 that cycle; an accept in the same cycle is NOT counted (clear wins).
//  - rst mid-stream: all buffered beats are discarded, counter cleared, state EMPTY; no partial output.
// TESTING
//  1. mode=01, LANES=4, in_data=32'h7A_61_5B_40 keep=F, out_ready=1 -> next clk out_data=32'h5A_41_5B_40, chg_cnt=2.
//  2. mode=11, bytes "aZ{`" (61 5A 7B 60) -> 41 7A 7B 60; chg_cnt+=2. Boundary bytes 40/5B/60/7B are unchanged.
//  3. keep=4'b0101, mode=01, data 61 61 61 61 -> out 61 41 61 41, out_keep=0101, chg_cnt+=2.
//  4. out_ready=0 with continuous in_valid -> two beats accepted, then in_ready=0; out_data stable.
//     Raise out_ready -> beats emerge in order, 1/clk, none lost.
//  5. Counter with CNT_W=4: 5 beats of 4 lowercase letters in upper mode -> chg_cnt=15 (saturated).
//     cnt_clr with a simultaneous accept -> chg_cnt=0.
//  6. rst asserted while in state TWO -> next clk out_valid=0, chg_cnt=0, in_ready=1 one clk after release.

Source files
------------

// File: rtl/case_convert_stream.sv
// case_convert_stream
//   Streaming ASCII case converter. Each beat carries LANES bytes; letters
//   (a-z / A-Z) in kept lanes are converted according to mode, and every
//   other byte passes through unchanged. Conversion happens on accept, so the
//   output stage (main register plus one skid register) always holds
//   already-converted beats. A saturating counter tracks how many bytes were
//   actually changed.
//
// Ports
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   mode            00 pass, 01 upper, 10 lower, 11 toggle (sampled on accept)
//   in_valid/ready  input handshake; in_ready is a flop
//   in_data/keep    input beat; lane i = in_data[8i+7:8i], keep bit i
//   out_valid/ready output handshake
//   out_data/keep   converted beat and its keep mask
//   cnt_clr         clear the changed-byte counter (wins over an accept)
//   chg_cnt         saturating count of bytes whose value changed
//
// Handshake: a beat moves on a rising edge where valid & ready are both 1.
// valid never depends on ready; once out_valid is asserted, out_data and
// out_keep hold until the beat is taken.

module case_convert_stream #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic [LANES-1:0]   in_keep,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic [LANES-1:0]   out_keep,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   chg_cnt
);

    localparam int INC_W = $clog2(LANES + 1);
    localparam int EXT_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t state;
    occ_t state_next;

    logic [8*LANES-1:0] conv_data;
    logic [LANES-1:0]   changed;
    logic [INC_W-1:0]   inc;
    logic [EXT_W-1:0]   cnt_ext;

    logic [8*LANES-1:0] skid_data;
    logic [LANES-1:0]   skid_keep;

    logic accept;
    logic emit;
    logic load_main_conv;
    logic load_main_skid;
    logic load_skid;

    // Returns 1 when bit 5 of the byte must be inverted for this mode.
    function automatic logic lane_flip(input logic [7:0] b, input logic [1:0] m);
        logic letter;
        letter = ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
        case (m)
            2'b01:   lane_flip = letter & b[5];
            2'b10:   lane_flip = letter & ~b[5];
            2'b11:   lane_flip = letter;
            default: lane_flip = 1'b0;
        endcase
    endfunction

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    // Conversion only ever touches bit 5 of kept lanes, so a lane changed
    // exactly when its flip condition holds.
    always_comb begin
        conv_data = in_data;
        changed   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_keep[i] && lane_flip(in_data[8*i +: 8], mode)) begin
                conv_data[8*i+5] = ~in_data[8*i+5];
                changed[i]       = 1'b1;
            end
        end
    end

    always_comb begin
        inc = '0;
        for (int i = 0; i < LANES; i++) begin
            inc = inc + INC_W'(changed[i]);
        end
        cnt_ext = EXT_W'(chg_cnt) + EXT_W'(inc);
    end

    // Occupancy FSM and register load selects.
    always_comb begin
        state_next     = state;
        load_main_conv = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next     = ONE;
                    load_main_conv = 1'b1;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    load_main_conv = 1'b1;
                end else if (accept) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (emit) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (emit) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_keep  <= '0;
            skid_data <= '0;
            skid_keep <= '0;
        end else begin
            if (load_main_conv) begin
                out_data <= conv_data;
                out_keep <= in_keep;
            end else if (load_main_skid) begin
                out_data <= skid_data;
                out_keep <= skid_keep;
            end
            if (load_skid) begin
                skid_data <= conv_data;
                skid_keep <= in_keep;
            end
        end
    end

    // Clear takes priority over a same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            chg_cnt <= '0;
        end else if (accept) begin
            if (cnt_ext > EXT_W'(CNT_MAX)) begin
                chg_cnt <= CNT_MAX;
            end else begin
                chg_cnt <= cnt_ext[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_case_convert_stream.sv
module tb_case_convert_stream;

  localparam int LANES = 4;
  localparam int CNT_W = 4;
  localparam int W = 8 * LANES;
  localparam int QW = W + LANES;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic [LANES-1:0] in_keep = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_data;
  logic [LANES-1:0] out_keep;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] chg_cnt;

  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] head;
  int exp_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;

  case_convert_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .cnt_clr(cnt_clr), .chg_cnt(chg_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // reference model: ASCII arithmetic, not bit manipulation
  function automatic logic [7:0] conv_byte(input logic [7:0] b, input logic [1:0] md);
    logic is_low, is_up;
    is_low = (b >= "a") && (b <= "z");
    is_up  = (b >= "A") && (b <= "Z");
    conv_byte = b;
    case (md)
      2'b01: if (is_low) conv_byte = b - 8'd32;
      2'b10: if (is_up) conv_byte = b + 8'd32;
      2'b11: begin
        if (is_low) conv_byte = b - 8'd32;
        else if (is_up) conv_byte = b + 8'd32;
      end
      default: conv_byte = b;
    endcase
  endfunction

  function automatic logic [W-1:0] conv_beat(input logic [W-1:0] d, input logic [LANES-1:0] k,
                                              input logic [1:0] md);
    conv_beat = d;
    for (int i = 0; i < LANES; i++)
      if (k[i]) conv_beat[8*i +: 8] = conv_byte(d[8*i +: 8], md);
  endfunction

  function automatic int count_changes(input logic [W-1:0] d, input logic [LANES-1:0] k,
                                       input logic [1:0] md);
    count_changes = 0;
    for (int i = 0; i < LANES; i++)
      if (k[i] && (conv_byte(d[8*i +: 8], md) != d[8*i +: 8])) count_changes++;
  endfunction

  // scoreboard monitor: checks current outputs, then predicts the next edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      check_eq("chg_cnt", chg_cnt, exp_cnt);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_beat", out_valid, 1'b0);
        end else begin
          head = exp_q[0];
          check_eq("out_data", out_data, head[W-1:0]);
          check_eq("out_keep", out_keep, head[QW-1:W]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_keep, conv_beat(in_data, in_keep, mode)});
      if (cnt_clr) begin
        exp_cnt = 0;
      end else if (in_valid && in_ready) begin
        exp_cnt += count_changes(in_data, in_keep, mode);
        if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
      end
    end
  end

  // driver tasks (called at posedge+1)
  task automatic send(input logic [W-1:0] d, input logic [LANES-1:0] k, input logic [1:0] md,
                      input bit rnd);
    int waited;
    bit got;
    waited = 0;
    got = 1'b0;
    in_data = d;
    in_keep = k;
    mode = md;
    in_valid = 1'b1;
    while (!got && waited < 64) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        waited++;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
    end
    check_eq("accepted", got, 1'b1);
    in_valid = 1'b0;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_keep", out_keep, 0);
    check_eq("rst_chg_cnt", chg_cnt, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_in_ready_up", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // upper mode
    clear_cnt();
    send(32'h7A615B40, 4'hF, 2'b01, 1'b0);
    @(negedge clk);
    check_eq("t1_valid", out_valid, 1'b1);
    check_eq("t1_data", out_data, 32'h5A415B40);
    check_eq("t1_cnt", chg_cnt, 2);
    drain();

    // toggle with boundary bytes
    clear_cnt();
    send(32'h615A7B60, 4'hF, 2'b11, 1'b0);
    @(negedge clk);
    check_eq("t2_data", out_data, 32'h417A7B60);
    check_eq("t2_cnt", chg_cnt, 2);
    drain();
    for (int m = 0; m < 4; m++) begin
      send(32'h405B607B, 4'hF, 2'(m), 1'b0);
      @(negedge clk);
      check_eq("t2_boundary", out_data, 32'h405B607B);
    end
    drain();

    // keep mask
    clear_cnt();
    send(32'h61616161, 4'b0101, 2'b01, 1'b0);
    @(negedge clk);
    check_eq("t3_data", out_data, 32'h61416141);
    check_eq("t3_keep", out_keep, 4'b0101);
    check_eq("t3_cnt", chg_cnt, 2);
    drain();

    // backpressure: skid fills, in_ready drops, data held
    out_ready = 1'b0;
    send(32'h61626364, 4'hF, 2'b01, 1'b0);
    send(32'h65666768, 4'hF, 2'b10, 1'b0);
    in_data = 32'h696A6B6C;
    in_keep = 4'hF;
    mode = 2'b11;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t4_in_ready_low", in_ready, 1'b0);
      check_eq("t4_hold", out_data, 32'h41424344);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t4_thruput", out_valid, 1'b1);
      if (in_ready && in_valid) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    drain();

    // saturation and clear-wins
    clear_cnt();
    for (int i = 0; i < 5; i++) send(32'h61626364, 4'hF, 2'b01, 1'b0);
    drain();
    @(negedge clk);
    check_eq("t5_sat", chg_cnt, 15);
    @(posedge clk);
    #1;
    cnt_clr = 1'b1;
    send(32'h61626364, 4'hF, 2'b01, 1'b0);
    cnt_clr = 1'b0;
    @(negedge clk);
    check_eq("t5_clr_wins", chg_cnt, 0);
    drain();

    // reset while holding two beats
    clear_cnt();
    out_ready = 1'b0;
    send(32'h61624142, 4'hF, 2'b01, 1'b0);
    send(32'h63644344, 4'hF, 2'b10, 1'b0);
    @(negedge clk);
    check_eq("t6_full", in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("t6_out_valid", out_valid, 1'b0);
    check_eq("t6_cnt", chg_cnt, 0);
    check_eq("t6_out_data", out_data, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("t6_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // random traffic with random backpressure and clears
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] d;
      for (int j = 0; j < LANES; j++) d[8*j +: 8] = 8'($urandom_range(32'h30, 32'h7F));
      cnt_clr = ($urandom_range(0, 7) == 0);
      send(d, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b1);
      cnt_clr = 1'b0;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
